// File: rtl/host_byte_fifo.sv
// host_byte_fifo
//   Byte FIFO between the host serial receiver and the command processor.
//   It presents a first-word-fall-through RTS/RTR stream and reports the
//   fill level and a sticky overflow flag.
//
// Ports
//   clk           clock, all logic on posedge
//   reset         synchronous, active-high
//   rx_valid      strobe: rx_data holds a new byte
//   rx_data       received byte
//   host_rtr      consumer ready to receive
//   host_rts      FIFO non-empty, host_data valid
//   host_data     byte at head of FIFO (8'h00 when empty)
//   fifo_count    entries held, 0..DEPTH
//   overflow      sticky: a byte was dropped because the FIFO was full
//   overflow_clr  clears overflow (a coincident drop wins)
module host_byte_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              host_rtr,
   output logic              host_rts,
   output logic [7:0]        host_data,
   output logic [ADDR_W:0]   fifo_count,
   output logic              overflow,
   input  logic              overflow_clr
);

   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              rd_en;
   logic              wr_en;
   logic              drop;

   assign full  = (count == FULL_COUNT);
   assign rd_en = host_rts && host_rtr;
   // A read in the same cycle frees a slot, so a full FIFO still accepts.
   assign wr_en = rx_valid && (!full || rd_en);
   assign drop  = rx_valid && full && !rd_en;

   assign host_rts   = (count != '0);
   assign host_data  = host_rts ? mem[rd_ptr] : 8'h00;
   assign fifo_count = count;

   // Storage is intentionally not reset; count gates visibility.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= rx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end else if (overflow_clr) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_host_byte_fifo.sv
module tb_host_byte_fifo;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       host_rtr = 1'b0;
   logic       host_rts;
   logic [7:0] host_data;
   logic [4:0] fifo_count;
   logic       overflow;
   logic       overflow_clr = 1'b0;

   host_byte_fifo #(.DEPTH(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .host_rtr     (host_rtr),
      .host_rts     (host_rts),
      .host_data    (host_data),
      .fifo_count   (fifo_count),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] sb_q[$];
   logic       model_ovf = 1'b0;
   logic [7:0] last_pop = 8'h00;
   int         pops = 0;

   typedef struct {
      logic       rv;
      logic [7:0] d;
      logic       rtr;
      logic       exp_rts;
      logic [7:0] exp_data;
      logic [4:0] exp_count;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive at negedge, score any pop before the edge,
   // advance the reference queue, then compare all outputs after the edge.
   task automatic step(input logic rv, input logic [7:0] d, input logic rtr, input logic clr);
      logic       rd;
      logic       was_full;
      logic [7:0] exp;
      @(negedge clk);
      rx_valid     = rv;
      rx_data      = d;
      host_rtr     = rtr;
      overflow_clr = clr;
      #1;
      was_full = (sb_q.size() == 16);
      rd = (sb_q.size() != 0) && rtr;
      if (rd) begin
         exp = sb_q.pop_front();
         chk("pop_data", host_data, exp);
         last_pop = exp;
         pops++;
      end
      if (rv) begin
         if (!was_full || rd) sb_q.push_back(d);
         else model_ovf = 1'b1;
      end
      if (!(rv && was_full && !rd) && clr) model_ovf = 1'b0;
      @(posedge clk);
      #1;
      chk("rts", host_rts, sb_q.size() != 0);
      chk("count", fifo_count, sb_q.size());
      chk("ovf", overflow, model_ovf);
      chk("head", host_data, (sb_q.size() != 0) ? sb_q[0] : 8'h00);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset        = 1'b1;
      rx_valid     = 1'b0;
      host_rtr     = 1'b0;
      overflow_clr = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_rts", host_rts, 1'b0);
      chk("rst_count", fifo_count, 5'd0);
      chk("rst_data", host_data, 8'h00);
      chk("rst_ovf", overflow, 1'b0);
      sb_q.delete();
      model_ovf = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b1, 8'h12, 1'b1, 1'b1, 8'h12, 5'd1, 1'b0};
      vecs[1] = '{1'b1, 8'h34, 1'b1, 1'b1, 8'h34, 5'd1, 1'b0};
      vecs[2] = '{1'b1, 8'h56, 1'b1, 1'b1, 8'h56, 5'd1, 1'b0};
      vecs[3] = '{1'b1, 8'h78, 1'b1, 1'b1, 8'h78, 5'd1, 1'b0};
      vecs[4] = '{1'b1, 8'h9A, 1'b1, 1'b1, 8'h9A, 5'd1, 1'b0};
      vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};

      do_reset();

      // Streaming five command bytes with the consumer always ready.
      for (int i = 0; i < 6; i++) begin
         step(vecs[i].rv, vecs[i].d, vecs[i].rtr, 1'b0);
         chk("vec_rts", host_rts, vecs[i].exp_rts);
         chk("vec_data", host_data, vecs[i].exp_data);
         chk("vec_count", fifo_count, vecs[i].exp_count);
         chk("vec_ovf", overflow, vecs[i].exp_ovf);
      end
      chk("t1_pops", pops, 5);

      // Fill, then one byte too many is dropped.
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("t2_count", fifo_count, 5'd16);
      chk("t2_rts", host_rts, 1'b1);
      chk("t2_ovf", overflow, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t2_last", last_pop, 8'h0F);
      chk("t2_empty", fifo_count, 5'd0);

      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t6_clr", overflow, 1'b0);

      // Full with simultaneous read and write.
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      step(1'b1, 8'hA5, 1'b1, 1'b0);
      chk("t3_count", fifo_count, 5'd16);
      chk("t3_ovf", overflow, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t3_last", last_pop, 8'hA5);

      // Pointer wrap across several passes.
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 10; i++) step(1'b1, 8'((p * 37 + i * 13) ^ 8'h5A), 1'b0, 1'b0);
         for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
         chk("t4_count", fifo_count, 5'd0);
      end

      // Reset mid-operation discards stored bytes.
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      do_reset();
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t5_first", last_pop, 8'h3C);

      // Clear versus coincident drop.
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      chk("t6_set", overflow, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t6_clr2", overflow, 1'b0);
      step(1'b1, 8'hFE, 1'b0, 1'b1);
      chk("t6_setwins", overflow, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("t6_clr3", overflow, 1'b0);
      for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t6_last", last_pop, 8'h8F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
